// File: rtl/dcache_req_arb_pkg.sv
// Shared constants and types for the D-cache request arbiter.
package dcache_req_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int EXC_W   = 7;
  localparam logic [EXC_W-1:0] EXP_ADEM = 7'h08;

  // Byte-mask access sizes
  localparam logic [3:0] T_BYTE = 4'b0001;
  localparam logic [3:0] T_HALF = 4'b0011;
  localparam logic [3:0] T_WORD = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Only WORD and HALF have alignment requirements; any other mask is accepted.
  function automatic logic misaligned(input logic [3:0] typ, input logic [1:0] a);
    return ((typ == T_WORD) && (a != 2'b00)) || ((typ == T_HALF) && a[0]);
  endfunction

endpackage

// File: rtl/dcache_req_arb_if.sv
// Requester and cache-side bus of the D-cache request arbiter.
// Requester signals are packed per port: index 0 = LSU, index 1 = CACOP/uncached.
interface dcache_req_arb_if
  import dcache_req_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_REQ-1:0]             r_valid;
  logic [NUM_REQ-1:0]             r_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0] r_addr;
  logic [NUM_REQ-1:0][3:0]        r_type;
  logic [NUM_REQ-1:0]             r_we;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_wdata;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] resp_rdata;
  logic [NUM_REQ-1:0][EXC_W-1:0]  resp_exc;

  logic              c_valid;
  logic              c_ready;
  logic [ADDR_W-1:0] c_addr;
  logic [3:0]        c_type;
  logic              c_we;
  logic [DATA_W-1:0] c_wdata;
  logic              c_resp_valid;
  logic [DATA_W-1:0] c_resp_rdata;

  // Requesters + cache
  modport master (
    output r_valid, r_addr, r_type, r_we, r_wdata, c_ready, c_resp_valid, c_resp_rdata,
    input  r_ready, resp_valid, resp_rdata, resp_exc, c_valid, c_addr, c_type, c_we, c_wdata
  );

  // Arbiter
  modport slave (
    input  r_valid, r_addr, r_type, r_we, r_wdata, c_ready, c_resp_valid, c_resp_rdata,
    output r_ready, resp_valid, resp_rdata, resp_exc, c_valid, c_addr, c_type, c_we, c_wdata
  );
endinterface

// File: rtl/dcache_req_arb_rr_arb2.sv
// Two-way round-robin arbiter; last_grant advances only on an accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant
);
  logic last_grant;

  // Tie goes to the port that did not win last; a lone requester always wins.
  always_comb grant = req[1] & (~req[0] | ~last_grant);

  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst)
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant;

endmodule

// File: rtl/dcache_req_arb.sv
// D-cache request front end: arbitrates two requesters, buffers the winner,
// filters misaligned accesses and runs one cache access at a time.
module dcache_req_arb
  import dcache_req_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  dcache_req_arb_if.slave  bus
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        typ;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } rbuf_t;

  state_t            state, state_nx;
  rbuf_t             rbuf;
  logic              owner;
  logic [DATA_W-1:0] rdata_q;
  logic [EXC_W-1:0]  exc_q;
  logic              grant;
  logic              accept;
  logic              exc_hit;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.r_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Ready only in IDLE, only for the granted port.
  always_comb begin
    bus.r_ready = '0;
    if (state == S_IDLE) bus.r_ready[grant] = bus.r_valid[grant];
    accept = |bus.r_ready;
  end

  always_comb exc_hit = misaligned(rbuf.typ, rbuf.addr[1:0]);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept)           state_nx = S_CHECK;
      S_CHECK: state_nx = exc_hit ? S_RESP : S_ISSUE;
      S_ISSUE: if (bus.c_ready)      state_nx = S_WAIT;
      S_WAIT:  if (bus.c_resp_valid) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  // Capture the winning request.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rbuf  <= '0;
      owner <= 1'b0;
    end else if (accept) begin
      rbuf  <= '{addr: bus.r_addr[grant], typ: bus.r_type[grant],
                 we: bus.r_we[grant], wdata: bus.r_wdata[grant]};
      owner <= grant;
    end

  // Response payload: exception from CHECK or cache data from WAIT (stores return 0).
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdata_q <= '0;
      exc_q   <= '0;
    end else if (state == S_CHECK && exc_hit) begin
      rdata_q <= '0;
      exc_q   <= EXP_ADEM;
    end else if (state == S_WAIT && bus.c_resp_valid) begin
      rdata_q <= rbuf.we ? '0 : bus.c_resp_rdata;
      exc_q   <= '0;
    end

  // Cache request driven straight from rbuf so it is stable across stalls.
  always_comb begin
    bus.c_valid = (state == S_ISSUE);
    bus.c_addr  = rbuf.addr;
    bus.c_type  = rbuf.typ;
    bus.c_we    = rbuf.we;
    bus.c_wdata = rbuf.wdata;
  end

  // One-cycle response to the owner only.
  always_comb begin
    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    bus.resp_exc   = '0;
    if (state == S_RESP) begin
      bus.resp_valid[owner] = 1'b1;
      bus.resp_rdata[owner] = rdata_q;
      bus.resp_exc[owner]   = exc_q;
    end
  end

endmodule

// File: tb/tb_dcache_req_arb.sv
// Randomized + directed bench for dcache_req_arb against a transaction-level model.
module tb_dcache_req_arb;
  import dcache_req_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_req_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dcache_req_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_chk = 0;
  int   n_err = 0;
  logic lg_m;   // model: port that won the last accepted request

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  typ;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic [3:0] t, input logic w,
                              input logic [31:0] d);
    req_t r;
    r.addr = a; r.typ = t; r.we = w; r.wdata = d;
    return r;
  endfunction

  // Alignment rule written from the access-size table.
  function automatic logic [6:0] ref_exc(input req_t r);
    int sz;
    sz = (r.typ == 4'b1111) ? 4 : (r.typ == 4'b0011) ? 2 : 1;
    return ((r.addr % sz) != 0) ? EXP_ADEM : 7'd0;
  endfunction

  // One complete transaction starting in an idle cycle; the bench also plays the cache.
  task automatic run_txn(input logic [1:0] vmask, input req_t r0, input req_t r1, input bit keep,
                         input int stall, input int rlat, input logic [31:0] crd);
    req_t        rq[2];
    req_t        w;
    logic        win;
    logic [1:0]  oh;
    logic [6:0]  e_exc;
    logic [31:0] e_rd;
    int          e_lat;
    bit          acc = 0;
    bit          hs = 0;
    bit          done = 0;
    bit          crv_n;
    int          acc_cyc = 0;
    int          stall_left = stall;
    int          rcnt = -1;
    rq[0] = r0; rq[1] = r1;
    win   = (vmask == 2'b11) ? ~lg_m : vmask[1];
    oh    = 2'b01 << win;
    w     = rq[win];
    e_exc = ref_exc(w);
    e_rd  = (e_exc != 0 || w.we) ? 32'd0 : crd;
    e_lat = (e_exc != 0) ? 2 : 4 + stall + rlat;
    bus.r_valid = vmask;
    for (int p = 0; p < 2; p++) begin
      bus.r_addr[p]  = rq[p].addr;
      bus.r_type[p]  = rq[p].typ;
      bus.r_we[p]    = rq[p].we;
      bus.r_wdata[p] = rq[p].wdata;
    end
    bus.c_ready      = (stall == 0);
    bus.c_resp_valid = 1'b0;
    bus.c_resp_rdata = ~crd;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (!acc) begin
        chk("grant", bus.r_ready, oh);
        acc = 1; acc_cyc = cyc; lg_m = win;
      end else begin
        chk("ready_busy", bus.r_ready, 2'b00);
        if (e_exc != 0) chk("no_cvalid", bus.c_valid, 1'b0);
        if (hs) chk("cvalid_after_hs", bus.c_valid, 1'b0);
        if (bus.c_valid && !hs) begin
          chk("c_addr", bus.c_addr, w.addr);
          chk("c_type", bus.c_type, w.typ);
          chk("c_we", bus.c_we, w.we);
          chk("c_wdata", bus.c_wdata, w.wdata);
          if (bus.c_ready) begin hs = 1; rcnt = rlat; end
          else stall_left--;
        end
        if (bus.resp_valid != 2'b00) begin
          chk("resp_owner", bus.resp_valid, oh);
          chk("resp_lat", cyc - acc_cyc, e_lat);
          chk("resp_rdata", bus.resp_rdata[win], e_rd);
          chk("resp_exc", bus.resp_exc[win], e_exc);
          chk("other_resp", {bus.resp_rdata[~win], bus.resp_exc[~win]}, '0);
          done = 1;
        end
      end
      if (!done) begin
        crv_n = 1'b0;
        if (rcnt >= 0) begin
          if (rcnt == 0) crv_n = 1'b1;
          rcnt--;
        end
        @(posedge clk); #1;
        if (acc) bus.r_valid = keep ? (vmask & ~oh) : 2'b00;
        bus.c_ready      = (stall_left <= 0);
        bus.c_resp_valid = crv_n;
        bus.c_resp_rdata = crv_n ? crd : ~crd;
      end
    end
    if (!done) chk("resp_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.r_valid = 2'b00; bus.c_ready = 1'b0; bus.c_resp_valid = 1'b0;
  endtask

  function automatic logic [3:0] rnd_type();
    case ($urandom_range(0, 3))
      0: return 4'b0001;
      1: return 4'b0011;
      2: return 4'b1111;
      default: return 4'($urandom);
    endcase
  endfunction

  function automatic req_t rnd_req();
    return mk($urandom, rnd_type(), 1'($urandom), $urandom);
  endfunction

  req_t dmy;
  bit   hs_seen;

  initial begin
    rst = 1'b1;
    lg_m = 1'b1;
    bus.r_valid = '0; bus.r_addr = '0; bus.r_type = '0; bus.r_we = '0; bus.r_wdata = '0;
    bus.c_ready = 1'b0; bus.c_resp_valid = 1'b0; bus.c_resp_rdata = '0;
    dmy = mk(32'h0, 4'b0001, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.r_ready, 2'b00);
    chk("rst_resp", {bus.resp_valid, bus.resp_rdata, bus.resp_exc}, '0);
    chk("rst_cvalid", bus.c_valid, 1'b0);
    chk("rst_cbuf", {bus.c_addr, bus.c_type, bus.c_we}, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Plain load on port 0, cache answers in the first WAIT cycle
    run_txn(2'b01, mk(32'h1000, 4'b1111, 1'b0, 32'h0), dmy, 0, 0, 0, 32'hDEADBEEF);
    // Alignment filter on port 1
    run_txn(2'b10, dmy, mk(32'h1002, 4'b1111, 1'b0, 32'h0), 0, 0, 0, 32'h11111111);
    run_txn(2'b10, dmy, mk(32'h1001, 4'b0011, 1'b0, 32'h0), 0, 0, 0, 32'h22222222);
    run_txn(2'b10, dmy, mk(32'h1002, 4'b0011, 1'b0, 32'h0), 0, 0, 1, 32'h33333333);
    run_txn(2'b10, dmy, mk(32'h1003, 4'b0001, 1'b0, 32'h0), 0, 0, 0, 32'h44444444);
    // Continuous contention: expect alternation, first with a 3-cycle cache stall
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, mk(32'h4000 + i*8, 4'b1111, 1'b0, 32'h0),
              mk(32'h5000 + i*8, 4'b1111, 1'b0, 32'h0), 1, (i == 0) ? 3 : 0, 0, $urandom);
    // Store: write data forwarded, response data zero
    run_txn(2'b01, mk(32'h2000, 4'b1111, 1'b1, 32'h12345678), dmy, 0, 0, 0, 32'hCAFEF00D);

    // Reset while WAITing for the cache
    bus.r_valid = 2'b01; bus.r_addr[0] = 32'h3000; bus.r_type[0] = 4'b1111; bus.r_we[0] = 1'b0;
    bus.c_ready = 1'b1;
    hs_seen = 0;
    for (int i = 0; i < 8 && !hs_seen; i++) begin
      @(negedge clk);
      if (i == 0) chk("rst_acc", bus.r_ready, 2'b01);
      hs_seen = bus.c_valid && bus.c_ready;
      @(posedge clk); #1 bus.r_valid = 2'b00;
    end
    if (!hs_seen) chk("rst_hs_timeout", 1'b0, 1'b1);
    bus.c_ready = 1'b0;
    rst = 1'b1;
    lg_m = 1'b1;
    @(negedge clk);
    chk("midrst_cvalid", bus.c_valid, 1'b0);
    chk("midrst_resp", bus.resp_valid, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_resp", bus.resp_valid, 2'b00);
    @(posedge clk); #1;
    run_txn(2'b11, mk(32'h6000, 4'b1111, 1'b0, 32'h0), mk(32'h7000, 4'b1111, 1'b0, 32'h0),
            0, 0, 0, 32'hA5A5A5A5);

    // Stray cache response while idle
    bus.c_resp_valid = 1'b1; bus.c_resp_rdata = 32'hBADBAD00;
    @(negedge clk);
    chk("spur_resp", bus.resp_valid, 2'b00);
    chk("spur_cvalid", bus.c_valid, 1'b0);
    @(posedge clk); #1 bus.c_resp_valid = 1'b0;
    @(negedge clk);
    chk("spur_resp2", bus.resp_valid, 2'b00);
    @(posedge clk); #1;
    run_txn(2'b01, mk(32'h8004, 4'b1111, 1'b0, 32'h0), dmy, 0, 1, 2, 32'h0BADC0DE);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] vm;
      vm = 2'($urandom_range(1, 3));
      run_txn(vm, rnd_req(), rnd_req(), 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
